// File: rtl/demux_pkg.sv
// Shared constants and helpers for the decoupled 1-to-N demux.
package demux_pkg;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 8;
    localparam logic [7:0] DROP_CNT_MAX = 8'd255;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width of the destination field for an N-port demux.
    function automatic int dest_width(input int n);
        return clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry ready/valid holding register; accepts a new beat while its current one drains.
module demux_slot
    import demux_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_bits,
    output logic         can_load
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (load) begin
            full_d = 1'b1;
            data_d = load_bits;
        end else if (full_q && out_ready) begin
            // Drain leaves the data in place; only the valid flag drops.
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign out_valid = full_q;
    assign out_bits  = data_q;
    assign can_load  = !full_q || out_ready;

endmodule

// File: rtl/decoupled_demux.sv
// 1-to-N ready/valid router with one holding slot per output and a drop pulse for bad destinations.
// Optional drop counter enabled by DECOUPLED_DEMUX_DROP_CNT_EN.
module decoupled_demux
    import demux_pkg::*;
#(
    parameter int  N  = N_DEFAULT,
    parameter int  W  = W_DEFAULT,
    localparam int DW = dest_width(N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                io_in_valid,
    output logic                io_in_ready,
    input  logic [W-1:0]        io_in_bits,
    input  logic [DW-1:0]       io_in_dest,
    output logic [N-1:0]        io_out_valid,
    input  logic [N-1:0]        io_out_ready,
    output logic [N-1:0][W-1:0] io_out_bits,
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
    output logic [7:0]          io_drop_count,
`endif
    output logic                io_drop
);

    logic [N-1:0] dest_hit;
    logic [N-1:0] can_load;
    logic [N-1:0] load;
    logic         in_range;
    logic         drop_q, drop_d;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slot
            assign dest_hit[gi] = (io_in_dest == DW'(gi));
            assign load[gi]     = io_in_valid && dest_hit[gi] && can_load[gi];

            demux_slot #(.W(W)) u_slot (
                .clk       (clk),
                .reset     (reset),
                .load      (load[gi]),
                .load_bits (io_in_bits),
                .out_valid (io_out_valid[gi]),
                .out_ready (io_out_ready[gi]),
                .out_bits  (io_out_bits[gi]),
                .can_load  (can_load[gi])
            );
        end
    endgenerate

    // No one-hot hit means the destination is past the last port: accept and discard.
    assign in_range    = |dest_hit;
    assign io_in_ready = !in_range || |(dest_hit & can_load);
    assign drop_d      = io_in_valid && !in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign io_drop = drop_q;

`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && drop_cnt_q != DROP_CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign io_drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_decoupled_demux.sv
// Directed bench: a 4-port instance for routing/back-pressure/reset, a 3-port one for drops.
module tb_decoupled_demux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-port instance
    logic            a_in_valid, a_in_ready;
    logic [7:0]      a_in_bits;
    logic [1:0]      a_in_dest;
    logic [3:0]      a_out_valid, a_out_ready;
    logic [3:0][7:0] a_out_bits;
    logic            a_drop;
    // 3-port instance
    logic            b_in_valid, b_in_ready;
    logic [7:0]      b_in_bits;
    logic [1:0]      b_in_dest;
    logic [2:0]      b_out_valid, b_out_ready;
    logic [2:0][7:0] b_out_bits;
    logic            b_drop;
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
    logic [7:0]      a_drop_count, b_drop_count;
`endif

    decoupled_demux #(.N(4), .W(8)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (a_in_valid),
        .io_in_ready  (a_in_ready),
        .io_in_bits   (a_in_bits),
        .io_in_dest   (a_in_dest),
        .io_out_valid (a_out_valid),
        .io_out_ready (a_out_ready),
        .io_out_bits  (a_out_bits),
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
        .io_drop_count(a_drop_count),
`endif
        .io_drop      (a_drop)
    );

    decoupled_demux #(.N(3), .W(8)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .io_in_valid  (b_in_valid),
        .io_in_ready  (b_in_ready),
        .io_in_bits   (b_in_bits),
        .io_in_dest   (b_in_dest),
        .io_out_valid (b_out_valid),
        .io_out_ready (b_out_ready),
        .io_out_bits  (b_out_bits),
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
        .io_drop_count(b_drop_count),
`endif
        .io_drop      (b_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        in_valid;
        logic [1:0]  dest;
        logic [7:0]  bits;
        logic [3:0]  out_ready;
        logic        exp_ready;
        logic [3:0]  exp_valid;
        logic [31:0] exp_bits;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [1:0] d, input logic [7:0] b,
                       input logic [3:0] r, input logic er, input logic [3:0] ev,
                       input logic [31:0] eb);
        vec_t t;
        t.in_valid = v; t.dest = d; t.bits = b; t.out_ready = r;
        t.exp_ready = er; t.exp_valid = ev; t.exp_bits = eb;
        vecs.push_back(t);
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_bits = 8'h00; a_in_dest = 2'd0; a_out_ready = 4'b1111;
        b_in_valid = 1'b0; b_in_bits = 8'h00; b_in_dest = 2'd0; b_out_ready = 3'b111;

        // Expected state is what the outputs show just after the edge that consumes the vector.
        add(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00000000);
        add(1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 32'h00A50000);
        add(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h00A50000);
        add(1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0010, 32'h00A51100);
        add(1'b0, 2'd1, 8'h00, 4'b1101, 1'b0, 4'b0010, 32'h00A51100);
        add(1'b0, 2'd3, 8'h00, 4'b1101, 1'b1, 4'b0010, 32'h00A51100);
        add(1'b1, 2'd3, 8'h33, 4'b1101, 1'b1, 4'b1010, 32'h33A51100);
        add(1'b1, 2'd1, 8'h99, 4'b0101, 1'b0, 4'b1010, 32'h33A51100);
        add(1'b1, 2'd1, 8'h22, 4'b1111, 1'b1, 4'b0010, 32'h33A52200);
        add(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h33A52200);
        for (int k = 1; k <= 8; k++) begin
            add(1'b1, 2'd0, 8'(k), 4'b1111, 1'b1, 4'b0001, {24'h33A522, 8'(k)});
        end
        add(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 32'h33A52208);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", {28'd0, a_out_valid}, 32'd0);
        chk("rst_bits", a_out_bits, 32'd0);
        chk("rst_drop", {31'd0, a_drop}, 32'd0);
        chk("rst_b_valid", {29'd0, b_out_valid}, 32'd0);
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
        chk("rst_count", {24'd0, b_drop_count}, 32'd0);
`endif
        for (int d = 0; d < 4; d++) begin
            a_in_dest = 2'(d);
            #1;
            chk($sformatf("rst_ready_d%0d", d), {31'd0, a_in_ready}, 32'd1);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            a_in_valid  = vecs[i].in_valid;
            a_in_dest   = vecs[i].dest;
            a_in_bits   = vecs[i].bits;
            a_out_ready = vecs[i].out_ready;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, a_in_ready}, {31'd0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {28'd0, a_out_valid}, {28'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_bits", i), a_out_bits, vecs[i].exp_bits);
            chk($sformatf("v%0d_drop", i), {31'd0, a_drop}, 32'd0);
        end

        // Mid-operation reset: fill slots 0 and 2, then reset with a beat on the input.
        @(negedge clk);
        a_out_ready = 4'b0000;
        a_in_valid = 1'b1; a_in_dest = 2'd0; a_in_bits = 8'h5A;
        @(negedge clk);
        a_in_dest = 2'd2; a_in_bits = 8'hC3;
        @(posedge clk);
        #1;
        chk("fill_valid", {28'd0, a_out_valid}, 32'h5);
        chk("fill_bits", a_out_bits, 32'h33C3225A);
        @(negedge clk);
        reset = 1'b1;
        a_in_dest = 2'd1; a_in_bits = 8'h77;
        @(posedge clk);
        #1;
        chk("midrst_valid", {28'd0, a_out_valid}, 32'd0);
        chk("midrst_bits", a_out_bits, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        a_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_valid", {28'd0, a_out_valid}, 32'd0);
        chk("postrst_bits", a_out_bits, 32'd0);

        // Out-of-range destination on the 3-port instance.
        @(negedge clk);
        b_in_valid = 1'b1; b_in_dest = 2'd3; b_in_bits = 8'hFF;
        #1;
        chk("drop_ready", {31'd0, b_in_ready}, 32'd1);
        chk("drop_pre", {31'd0, b_drop}, 32'd0);
        @(posedge clk);
        #1;
        chk("drop_pulse", {31'd0, b_drop}, 32'd1);
        chk("drop_valid", {29'd0, b_out_valid}, 32'd0);
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
        chk("drop_count1", {24'd0, b_drop_count}, 32'd1);
`endif
        @(negedge clk);
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_end", {31'd0, b_drop}, 32'd0);
        chk("drop_end_valid", {29'd0, b_out_valid}, 32'd0);

        // In-range beat on the 3-port instance still routes normally.
        @(negedge clk);
        b_in_valid = 1'b1; b_in_dest = 2'd1; b_in_bits = 8'h6C; b_out_ready = 3'b000;
        @(posedge clk);
        #1;
        chk("b_route_valid", {29'd0, b_out_valid}, 32'h2);
        chk("b_route_bits", b_out_bits, 32'h006C00);
        chk("b_route_drop", {31'd0, b_drop}, 32'd0);

        // 299 further back-to-back drops: counter saturates.
        @(negedge clk);
        b_in_dest = 2'd3; b_in_bits = 8'hFF; b_out_ready = 3'b111;
        repeat (299) @(posedge clk);
        #1;
        chk("drop_stream", {31'd0, b_drop}, 32'd1);
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
        chk("drop_count_sat", {24'd0, b_drop_count}, 32'd255);
`endif
        @(negedge clk);
        b_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_stream_end", {31'd0, b_drop}, 32'd0);
`ifdef DECOUPLED_DEMUX_DROP_CNT_EN
        chk("drop_count_hold", {24'd0, b_drop_count}, 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoupled_demux.md
Name: decoupled_demux

Overview:
- 1-to-N decoupled router: the opposite direction of the N-to-1 priority arbiter.
- Accepts one beat per cycle on a single ready/valid input, tagged with a destination index.
- Steers each beat into a one-entry holding register per output, which drives that output's ready/valid port.
- Sits downstream of a shared producer, fanning traffic out to N independent consumers; a stalled consumer blocks only beats addressed to it.

Parameters:
- N, 4, number of output ports (2..16)
- W, 8, data width in bits
- DW, clog2(N), destination field width (derived, not overridable)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- io_in_valid  input  1  producer has a beat
- io_in_ready  output  1  beat accepted this cycle when high with valid
- io_in_bits  input  W  payload
- io_in_dest  input  DW  destination output index
- io_out_k_valid  output  1  (k = 0..N-1) slot k holds a beat
- io_out_k_ready  input  1  consumer k takes the beat
- io_out_k_bits  output  W  slot k payload
- io_drop  output  1  one-cycle pulse: beat with dest >= N discarded

Behaviour:
- Transfer rules:
  - Input transfer = io_in_valid & io_in_ready.
  - Output transfer k = io_out_k_valid & io_out_k_ready.
- Per-slot state: full_k (1 bit) and data_k (W bits).
  - Reset: all full_k = 0, all data_k = 0, io_drop = 0.
  - Consequently every io_out_k_valid = 0 and io_out_k_bits = 0 after reset.
- io_in_ready (combinational):
  - dest < N: !full_dest | io_out_dest_ready (pass-through of the same-cycle drain).
  - dest >= N: 1.
  - Holds regardless of io_in_valid.
- Latency:
  - A beat accepted in cycle t appears on io_out_dest_valid/bits in cycle t+1.
  - No combinational path from io_in_bits to io_out_*_bits.
- Slot k next state:
  - Load only: full_k <= 1, data_k <= io_in_bits.
  - Drain only: full_k <= 0; data_k holds its value (not cleared).
  - Load and drain in the same cycle: full_k stays 1, data_k <= new beat (full throughput, one beat/cycle per port).
  - Neither: hold.
- Only slot io_in_dest can load in a cycle. Other slots drain independently and concurrently.
- Out-of-range dest (possible only when N is not a power of 2):
  - Beat is accepted (ready = 1) and discarded.
  - io_drop is registered: high in cycle t+1 for an accept in cycle t; otherwise 0.
- Stability:
  - While io_out_k_valid is high and io_out_k_ready is low, io_out_k_bits is stable.
  - io_out_k_valid never deasserts without a transfer.
- io_in_valid low: no slot loads, io_drop stays 0. io_in_bits and io_in_dest are don't-care.
- Reset asserted mid-operation:
  - Next cycle all slots are empty and any held beats are lost.
  - A beat presented during the reset cycle is not stored.
  - io_in_ready keeps its combinational value during reset; producers must not rely on acceptance while reset is high.
- Ordering: beats to the same destination leave in acceptance order. No ordering guarantee across destinations.

Optional Feature:
- Macro: DECOUPLED_DEMUX_DROP_CNT_EN
- Defined:
  - Adds output port io_drop_count (8 bits).
  - Counts discarded beats; saturates at 255; reset to 0; increments in the same cycle io_drop pulses.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package demux_pkg:
  - clog2 function
  - DW derivation
  - defaults N_DEFAULT = 4 and W_DEFAULT = 8
  - DROP_CNT_MAX = 255
- Sub-module demux_slot:
  - One-entry ready/valid holding register with parameter W.
  - Ports: clk, reset, load, load_bits, out_valid, out_ready, out_bits, plus combinational can_load = !full | out_ready.
  - Instantiated N times; the top level decodes io_in_dest and muxes can_load into io_in_ready.

Test Plan:
- Reset then idle: hold reset 2 cycles, then release with io_in_valid = 0 → all io_out_k_valid = 0, io_out_k_bits = 0, io_drop = 0, io_in_ready = 1 for every dest.
- Single route: with all out_ready = 1, send bits = 0xA5, dest = 2 in cycle t → io_out_2_valid = 1 and bits = 0xA5 in t+1 only; other outputs stay invalid.
- Back-pressure isolation:
  - Hold io_out_1_ready = 0 and send 0x11 to dest 1 → slot 1 full.
  - Next, dest = 1 gives io_in_ready = 0 and dest = 3 gives io_in_ready = 1.
  - Send 0x33 to dest 3 → it emerges on port 3 while port 1 still shows 0x11.
- Full throughput on one port: out_0_ready = 1; stream 0x01..0x08 to dest 0 back-to-back → io_in_ready stays 1 and port 0 shows 0x01..0x08 on consecutive cycles with no bubble.
- Out-of-range (N = 3): send dest = 3, bits = 0xFF → accepted, io_drop pulses once in t+1, no output valid. With DECOUPLED_DEMUX_DROP_CNT_EN, io_drop_count = 1 after one drop and 255 after 300 drops.
- Mid-operation reset: fill slots 0 and 2 with all ready = 0, assert reset for 1 cycle → all valids = 0 next cycle; a beat offered during reset does not appear afterwards.
